vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 128 KB main video RAM (15-bit word address, 32-bit data, byte enables,
//  1-cycle registered read) between NUM_PORTS requesters: port 0 = host/CPU interface, ports 1..N-1 =
//  renderers/DMA. Port 0 has fixed priority; the others rotate round-robin. A wait-counter starvation
//  guard bounds the latency of every low-priority port. Sits between the requesters and the RAM block.
// PARAMETERS
//  NUM_PORTS  4   requester count, 2..8; port 0 is the priority port
//  MAX_WAIT   8   cycles a pending round-robin request may lose to port 0 before it is forced
//  ADDR_W     15  word address width (32-bit words)
// PORTS
//  clk            in   1                one clock for all logic
//  rst_n          in   1                asynchronous reset, active low
//  req            in   NUM_PORTS        per-port request; held high until ack
//  req_write      in   NUM_PORTS        per-port 1=write, 0=read
//  req_addr       in   NUM_PORTS*ADDR_W per-port word address, port p at [p*ADDR_W +: ADDR_W]
//  req_wrdata     in   NUM_PORTS*32     per-port write data
//  req_wrbytesel  in   NUM_PORTS*4      per-port byte enables (bit0 = [7:0])
//  ack            out  NUM_PORTS        one-hot grant, combinational, same cycle as the RAM access
//  rd_valid       out  NUM_PORTS        one-hot, 1 cycle after a read ack: rd_data valid for that port
//  rd_data        out  32               shared read data (RAM output passed through)
//  ram_addr       out  ADDR_W           to RAM bus_addr
//  ram_wrdata     out  32               to RAM bus_wrdata
//  ram_wrbytesel  out  4                to RAM bus_wrbytesel
//  ram_write      out  1                to RAM bus_write
//  ram_rddata     in   32               from RAM bus_rddata (valid the cycle after the address)
// BEHAVIOUR
//  - Reset (async assert, sync release): rr_ptr=1, all wait counters=0, rd_valid=0.
//    ack, ram_write, ram_addr, ram_wrdata, ram_wrbytesel = 0 whenever no request is granted.
//  - Grant, evaluated combinationally every cycle; at most one grant per cycle:
//    1) a port p>=1 with req && wait_cnt[p]==MAX_WAIT (forced); ties go to the first at/after rr_ptr;
//    2) else port 0 if req[0];
//    3) else the first requesting port p>=1 scanning from rr_ptr upward, wrapping N-1 -> 1.
//  - Granted port g: ack[g]=1, RAM bus = port g's fields, ram_write = req_write[g]. One access per
//    cycle, full throughput; back-to-back grants to the same port are allowed.
//  - A requester samples ack on the clk edge and then drops or changes its request; a request held
//    after ack is a new access.
//  - rr_ptr: on a grant to g>=1 it becomes g+1, wrapping N-1 -> 1; unchanged otherwise.
//  - wait_cnt[p] for p>=1: cleared when req[p]==0 or p is granted. Otherwise incremented, saturating
//    at MAX_WAIT. Worst-case latency for p>=1 is bounded by about (MAX_WAIT+1)*(NUM_PORTS-1) cycles.
//  - Read return: the registered rd_port/rd_pend are set on a read grant. On the next cycle
//    rd_valid[rd_port]=1 and rd_data=ram_rddata. A write grant makes rd_valid all-zero the next cycle.
//  - Read-after-write by different ports in consecutive cycles returns the new data, because the RAM
//    write takes effect at the edge.
//  - req with no ack is ignored; req_write/req_addr of non-granted ports are don't-care.
//  - Reset during a pending read drops the return: rd_valid=0 out of reset.
//  - NUM_PORTS=2: round-robin degenerates to port 1 only; the starvation guard still applies.
// STRUCTURE
//  - vram_pkg: VRAM_ADDR_W=15, VRAM_DATA_W=32, VRAM_BE_W=4, port index constants (PORT_HOST=0).
//  - Sub-module vram_arb_rr_pick: combinational rotating first-one finder
//    (in: mask[NUM_PORTS-1:1], rr_ptr; out: one-hot, valid). Instanced twice: forced set, normal set.
//  - Top level: priority select, bus mux, rr_ptr/wait_cnt registers, read-return register.
// TESTING
//  1. Reset: hold rst_n=0 with req=4'b1111 -> ack=0, ram_write=0, rd_valid=0.
//     Release -> first ack=4'b0001.
//  2. Port 0 write addr 0x0123, data 0xDEADBEEF, bytesel 4'b0101, then port 2 read 0x0123 the next
//     cycle -> ram_write pulse carries the exact fields. rd_valid=4'b0100 one cycle after port 2's
//     ack. rd_data=0xXXADXXEF, unwritten bytes at the RAM's prior values.
//  3. Ports 1,2,3 request continuously with port 0 idle -> acks rotate 1,2,3,1,2,3, one per cycle,
//     no bubbles.
//  4. Port 0 held high continuously plus port 3 with MAX_WAIT=8 -> port 3 acked exactly on its
//     9th pending cycle. Port 0 is acked in all other cycles.
//  5. Read grant to port 1, then rst_n pulsed low mid-cycle before the return -> rd_valid stays 0.
//     rr_ptr=1 and wait counters=0 after reset.
//  6. Random traffic on all ports against a reference memory model -> every read returns the model
//     value. No port waits longer than the starvation bound. ack is always one-hot or zero.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants for the video RAM arbiter: RAM geometry and fixed port roles.
// Imported by the arbiter top and its round-robin picker.
package vram_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_BE_W   = 4;

  localparam int PORT_HOST   = 0;
  localparam int PORT_RR_MIN = 1;

endpackage

// File: rtl/vram_arb_rr_pick.sv
// Rotating first-one finder over ports 1..NUM_PORTS-1, starting at rr_ptr and wrapping back to 1.
// Purely combinational; onehot is all-zero and valid low when the mask is empty.
module vram_arb_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:1] mask,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:1] onehot,
  output logic                 valid
);

  // Two passes: ports at/after the pointer first, then the wrapped ports below it.
  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    for (int p = 1; p < NUM_PORTS; p++) begin
      if (!valid && mask[p] && (p >= int'(rr_ptr))) begin
        onehot[p] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int p = 1; p < NUM_PORTS; p++) begin
      if (!valid && mask[p] && (p < int'(rr_ptr))) begin
        onehot[p] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: port 0 fixed priority, ports 1..N-1 round-robin with a wait-count starvation guard.
// Grant and RAM bus are combinational in the access cycle; read data returns one cycle later on rd_valid.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_WAIT  = 8,
  parameter int ADDR_W    = VRAM_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS*VRAM_DATA_W-1:0] req_wrdata,
  input  logic [NUM_PORTS*VRAM_BE_W-1:0] req_wrbytesel,
  output logic [NUM_PORTS-1:0]           ack,
  output logic [NUM_PORTS-1:0]           rd_valid,
  output logic [VRAM_DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [VRAM_DATA_W-1:0]         ram_wrdata,
  output logic [VRAM_BE_W-1:0]           ram_wrbytesel,
  output logic                           ram_write,
  input  logic [VRAM_DATA_W-1:0]         ram_rddata
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(PORT_RR_MIN);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_PORTS - 1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [CNT_W-1:0]     wait_cnt [NUM_PORTS-1:1];

  logic [NUM_PORTS-1:1] forced_mask;
  logic [NUM_PORTS-1:1] norm_mask;
  logic [NUM_PORTS-1:1] forced_oh;
  logic [NUM_PORTS-1:1] norm_oh;
  logic                 forced_vld;
  logic                 norm_vld;

  logic [NUM_PORTS-1:0] grant;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;

  logic                 rd_pend;
  logic [PTR_W-1:0]     rd_port;

  always_comb begin
    forced_mask = '0;
    for (int p = 1; p < NUM_PORTS; p++) begin
      forced_mask[p] = req[p] && (wait_cnt[p] == CNT_MAX);
    end
  end

  assign norm_mask = req[NUM_PORTS-1:1];

  vram_arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick_forced (
    .mask   (forced_mask),
    .rr_ptr (rr_ptr),
    .onehot (forced_oh),
    .valid  (forced_vld)
  );

  vram_arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick_norm (
    .mask   (norm_mask),
    .rr_ptr (rr_ptr),
    .onehot (norm_oh),
    .valid  (norm_vld)
  );

  // Grants are suppressed while reset is held so no access leaks onto the RAM bus.
  always_comb begin
    grant = '0;
    if (rst_n) begin
      if (forced_vld) begin
        grant = {forced_oh, 1'b0};
      end else if (req[PORT_HOST]) begin
        grant[PORT_HOST] = 1'b1;
      end else if (norm_vld) begin
        grant = {norm_oh, 1'b0};
      end
    end
  end

  assign grant_vld = |grant;
  assign ack       = grant;

  always_comb begin
    grant_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        grant_idx = PTR_W'(p);
      end
    end
  end

  always_comb begin
    ram_addr      = '0;
    ram_wrdata    = '0;
    ram_wrbytesel = '0;
    ram_write     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        ram_addr      = req_addr[p*ADDR_W +: ADDR_W];
        ram_wrdata    = req_wrdata[p*VRAM_DATA_W +: VRAM_DATA_W];
        ram_wrbytesel = req_wrbytesel[p*VRAM_BE_W +: VRAM_BE_W];
        ram_write     = req_write[p];
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_vld && (grant_idx != PTR_W'(PORT_HOST))) begin
      rr_ptr_nxt = (grant_idx == PTR_LAST) ? PTR_FIRST : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PTR_FIRST;
      for (int p = 1; p < NUM_PORTS; p++) begin
        wait_cnt[p] <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int p = 1; p < NUM_PORTS; p++) begin
        if (!req[p] || grant[p]) begin
          wait_cnt[p] <= '0;
        end else if (wait_cnt[p] != CNT_MAX) begin
          wait_cnt[p] <= wait_cnt[p] + 1'b1;
        end
      end
    end
  end

  // The RAM registers the read internally; only the destination port needs tracking here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_port <= '0;
    end else begin
      rd_pend <= grant_vld && !ram_write;
      rd_port <= grant_idx;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (rd_pend) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_port == PTR_W'(p)) begin
          rd_valid[p] = 1'b1;
        end
      end
    end
  end

  assign rd_data = ram_rddata;

endmodule
